lfsr_checker: RTL
=================

LFSR_CHECKER -- requirements
Module: lfsr_checker

Interface
REQ-001 Parameter: LOCK_CNT, 3, consecutive matching beats after the seed beat needed to declare lock (1..7).
REQ-002 Parameter: LOSS_CNT, 4, consecutive mismatching beats in lock needed to drop lock (1..7).
REQ-003 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-low reset; rst=0 forces the reset state immediately, independent of clk.
REQ-005 Port: din_valid  input  1  qualifies din; beats with din_valid=0 are ignored.
REQ-006 Port: din  input  4  received 4-bit LFSR state word from the generator.
REQ-007 Port: clr  input  1  synchronous clear of err_count.
REQ-008 Port: locked  output  1  registered; 1 while the checker is in LOCK.
REQ-009 Port: err  output  1  registered one-cycle pulse per mismatching beat in LOCK.
REQ-010 Port: err_count  output  8  registered mismatch count; saturates at 255.
REQ-011 Port: expected  output  4  registered predicted value of the next valid din.

Function
REQ-012 Next-state function f(s) = {s[2:0], s[3]^s[2]}, x^4+x^3+1, period 15; 0000 is the illegal lock-up word.
REQ-013 Worked check: from 1111 the sequence SHALL be 1111,1110,1100,1000,0001,0010,0100,1001,0011,0110,1101,1010,0101,1011,0111, then 1111.
REQ-014 FSM states: SEEK, ACQ, LOCK; only beats with din_valid=1 cause transitions or counter or expected updates.
REQ-015 din_valid=0: state, expected, match_cnt, miss_cnt, locked and err_count hold; err=0.
REQ-016 SEEK, din=0000: stay in SEEK.
REQ-017 SEEK, din≠0000: expected<=f(din), match_cnt<=0, go to ACQ.
REQ-018 ACQ, din==expected: expected<=f(din), match_cnt<=match_cnt+1; if match_cnt+1==LOCK_CNT, go to LOCK and set locked<=1 on the same edge.
REQ-019 ACQ, din≠expected and din≠0000: re-seed with expected<=f(din), match_cnt<=0, stay in ACQ.
REQ-020 ACQ, din≠expected and din==0000: go to SEEK.
REQ-021 ACQ: mismatches never assert err or change err_count.
REQ-022 LOCK, match: expected<=f(expected), miss_cnt<=0.
REQ-023 LOCK, mismatch (including din=0000): err<=1 for exactly one cycle, err_count<=err_count+1 unless already 255, expected<=f(expected) (flywheel, no re-seed), miss_cnt<=miss_cnt+1.
REQ-024 LOCK, mismatch with miss_cnt+1==LOSS_CNT: in addition, go to SEEK, locked<=0, miss_cnt<=0.
REQ-025 Latency: locked, err, err_count and expected reflect a beat after the clock edge that samples it (1 cycle).
REQ-026 clr=1: err_count<=0 on the edge, overriding a simultaneous increment; err still pulses for that beat.
REQ-027 Leaving LOCK (loss or reset) does not clear err_count; only clr or rst clears it.

Reset
REQ-028 rst=0 SHALL asynchronously set state=SEEK, expected=0000, match_cnt=0, miss_cnt=0, locked=0, err=0, err_count=0.
REQ-029 Reset asserted mid-ACQ or mid-LOCK aborts the operation; after rst returns to 1, the first valid nonzero beat is treated as a fresh seed.

Verification
REQ-030 Reset: drive rst=0 with din_valid=1, din=1010, clk toggling -> locked=0, err=0, err_count=0, expected=0000, all held while rst=0.
REQ-031 Acquire: valid beats 1111,1110,1100,1000 on consecutive cycles -> locked=1 after the 4th edge, expected=0001, err_count=0, err never pulses.
REQ-032 Single error: in lock, send 0000 instead of 0001, then 0010 -> one err pulse, err_count=1, locked stays 1, expected=0100 after the 0010 beat.
REQ-033 Loss of lock: in lock, send four consecutive beats of 0101 -> err pulses four times, err_count=+4, locked=0 after the 4th edge; then beats 1111,1110,1100,1000 re-lock.
REQ-034 Gaps and re-seed: acquire with din_valid=0 between every beat -> same lock result as REQ-031; in ACQ, send 1111,1110,0110 -> re-seed, expected=1101, still unlocked.
REQ-035 Saturation and clr: force 260 lock-mode errors (re-lock as needed) -> err_count=255; clr=1 during a mismatch beat -> err_count=0 and err=1 that cycle.

Source files
------------

// File: rtl/lfsr_checker_if.sv
// rtl/lfsr_checker_if.sv - beat input and lock/error status bundle for lfsr_checker
interface lfsr_checker_if;
  logic       din_valid;
  logic [3:0] din;
  logic       clr;
  logic       locked;
  logic       err;
  logic [7:0] err_count;
  logic [3:0] expected;

  modport master (
    output din_valid, din, clr,
    input  locked, err, err_count, expected
  );

  modport slave (
    input  din_valid, din, clr,
    output locked, err, err_count, expected
  );
endinterface

// File: rtl/lfsr_checker.sv
// rtl/lfsr_checker.sv - x^4+x^3+1 LFSR sequence checker with seed/acquire/lock tracking
// and a saturating mismatch counter.
module lfsr_checker #(
  parameter int unsigned LOCK_CNT = 3,
  parameter int unsigned LOSS_CNT = 4
) (
  input  logic           clk,
  input  logic           rst,
  lfsr_checker_if.slave  bus
);

  typedef enum logic [1:0] {
    SEEK = 2'd0,
    ACQ  = 2'd1,
    LOCK = 2'd2
  } state_e;

  localparam logic [3:0] LOCK_N = 4'(LOCK_CNT);
  localparam logic [3:0] LOSS_N = 4'(LOSS_CNT);

  function automatic logic [3:0] lfsr_next(input logic [3:0] s);
    return {s[2:0], s[3] ^ s[2]};
  endfunction

  state_e     state_q, state_d;
  logic [3:0] expected_q, expected_d;
  logic [2:0] match_cnt_q, match_cnt_d;
  logic [2:0] miss_cnt_q, miss_cnt_d;
  logic       locked_q, locked_d;
  logic       err_q, err_d;
  logic [7:0] err_count_q, err_count_d;

  logic [3:0] match_inc;
  logic [3:0] miss_inc;
  logic       din_zero;
  logic       din_hit;

  assign match_inc = {1'b0, match_cnt_q} + 4'd1;
  assign miss_inc  = {1'b0, miss_cnt_q} + 4'd1;
  assign din_zero  = (bus.din == 4'b0000);
  assign din_hit   = (bus.din == expected_q);

  always_comb begin
    state_d     = state_q;
    expected_d  = expected_q;
    match_cnt_d = match_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    locked_d    = locked_q;
    err_d       = 1'b0;
    err_count_d = err_count_q;

    if (bus.din_valid) begin
      unique case (state_q)
        SEEK: begin
          if (!din_zero) begin
            expected_d  = lfsr_next(bus.din);
            match_cnt_d = 3'd0;
            state_d     = ACQ;
          end
        end
        ACQ: begin
          if (din_hit) begin
            expected_d  = lfsr_next(bus.din);
            match_cnt_d = match_inc[2:0];
            if (match_inc == LOCK_N) begin
              state_d    = LOCK;
              locked_d   = 1'b1;
              miss_cnt_d = 3'd0;
            end
          end else if (!din_zero) begin
            expected_d  = lfsr_next(bus.din);
            match_cnt_d = 3'd0;
          end else begin
            state_d = SEEK;
          end
        end
        LOCK: begin
          // Flywheel: the prediction keeps running from itself, never from din.
          expected_d = lfsr_next(expected_q);
          if (din_hit) begin
            miss_cnt_d = 3'd0;
          end else begin
            err_d = 1'b1;
            if (err_count_q != 8'hFF) begin
              err_count_d = err_count_q + 8'd1;
            end
            if (miss_inc == LOSS_N) begin
              state_d    = SEEK;
              locked_d   = 1'b0;
              miss_cnt_d = 3'd0;
            end else begin
              miss_cnt_d = miss_inc[2:0];
            end
          end
        end
        default: begin
          state_d  = SEEK;
          locked_d = 1'b0;
        end
      endcase
    end

    if (bus.clr) begin
      err_count_d = 8'd0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= SEEK;
      expected_q  <= 4'b0000;
      match_cnt_q <= 3'd0;
      miss_cnt_q  <= 3'd0;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
      err_count_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      expected_q  <= expected_d;
      match_cnt_q <= match_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      locked_q    <= locked_d;
      err_q       <= err_d;
      err_count_q <= err_count_d;
    end
  end

  assign bus.locked    = locked_q;
  assign bus.err       = err_q;
  assign bus.err_count = err_count_q;
  assign bus.expected  = expected_q;

endmodule
